// File: rtl/tx_logic_if.sv
// tx_logic_if: bundles the TX FIFO handshake and the serial pin outputs of the
// SSP transmit block.
//   tx_fifo_empty - FIFO empty flag (FIFO -> tx)
//   TxData        - FIFO head word, first-word-fall-through (FIFO -> tx)
//   read_fifo     - one-PCLK pop strobe (tx -> FIFO)
//   SSPCLKOUT     - serial clock, PCLK/2
//   SSPFSSOUT     - frame sync, one SSPCLKOUT period ahead of each MSB
//   SSPTXD        - serial data, MSB first
//   SSPOE_B       - active-low pad output enable
// master = the transmitter, slave = the FIFO / pad side.
interface tx_logic_if #(parameter int DATA_WIDTH = 8);
  logic                  tx_fifo_empty;
  logic [DATA_WIDTH-1:0] TxData;
  logic                  read_fifo;
  logic                  SSPCLKOUT;
  logic                  SSPFSSOUT;
  logic                  SSPTXD;
  logic                  SSPOE_B;

  modport master (
    input  tx_fifo_empty, TxData,
    output read_fifo, SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B
  );

  modport slave (
    output tx_fifo_empty, TxData,
    input  read_fifo, SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B
  );
endinterface

// File: rtl/tx_logic.sv
// tx_logic: transmit half of the SSP serial port.
// Pops words from a first-word-fall-through TX FIFO and shifts them out MSB
// first on SSPTXD, clocked by SSPCLKOUT = PCLK/2. A one-period SSPFSSOUT pulse
// precedes each word; if the FIFO still has data when the last bit starts,
// FSS is raised over that last bit and the next word follows with no gap.
// Ports:
//   PCLK    - system clock, all logic on posedge
//   CLEAR_B - asynchronous active-low reset; aborts any frame in flight
//   bus     - tx_logic_if.master (FIFO handshake + serial pins)
module tx_logic #(
  parameter int DATA_WIDTH = 8
) (
  input  logic          PCLK,
  input  logic          CLEAR_B,
  tx_logic_if.master    bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SYNC, SHIFT} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic                  txd, txd_nx;
  logic                  fss, fss_nx;
  logic                  rd, rd_nx;
  logic                  clk_div;
  logic                  oe_b;
  logic                  tick;
  logic                  load;

  // SSPCLKOUT is 0 right before a tick edge, 1 right before a fall edge.
  assign tick = ~clk_div;

  // Divider, pop strobe and pad enable. The enable only moves on falls so
  // it brackets the frame by half a serial period on each side.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      clk_div <= 1'b0;
      rd      <= 1'b0;
      oe_b    <= 1'b1;
    end else begin
      clk_div <= ~clk_div;
      rd      <= rd_nx;
      if (!tick)
        oe_b <= ~((state == SYNC) || (state == SHIFT));
    end
  end

  // FSM and shift datapath, advanced on ticks only.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
      txd   <= 1'b0;
      fss   <= 1'b0;
    end else if (tick) begin
      state <= state_nx;
      cnt   <= cnt_nx;
      shreg <= shreg_nx;
      txd   <= txd_nx;
      fss   <= fss_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shreg_nx = shreg;
    txd_nx   = txd;
    fss_nx   = fss;
    load     = 1'b0;

    case (state)
      IDLE: begin
        txd_nx = 1'b0;
        fss_nx = 1'b0;
        if (!bus.tx_fifo_empty) begin
          fss_nx   = 1'b1;
          state_nx = SYNC;
        end
      end
      SYNC: begin
        // No empty re-check: only this block pops the FIFO.
        load = 1'b1;
      end
      SHIFT: begin
        if (cnt == LAST) begin
          // FSS raised over the last bit means a follow-on word is waiting.
          if (fss) begin
            load = 1'b1;
          end else begin
            txd_nx   = 1'b0;
            cnt_nx   = '0;
            state_nx = IDLE;
          end
        end else begin
          cnt_nx   = cnt + CW'(1);
          shreg_nx = shreg << 1;
          txd_nx   = shreg[DATA_WIDTH-2];
          if (cnt_nx == LAST)
            fss_nx = ~bus.tx_fifo_empty;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (load) begin
      shreg_nx = bus.TxData;
      txd_nx   = bus.TxData[DATA_WIDTH-1];
      fss_nx   = 1'b0;
      cnt_nx   = '0;
      state_nx = SHIFT;
    end
  end

  // Pop on the cycle after the load tick; the FIFO advances on the next
  // edge (a fall), so the new head is settled before the next tick.
  assign rd_nx = load & tick;

  assign bus.read_fifo = rd;
  assign bus.SSPCLKOUT = clk_div;
  assign bus.SSPFSSOUT = fss;
  assign bus.SSPTXD    = txd;
  assign bus.SSPOE_B   = oe_b;

endmodule

// File: tb/tb_tx_logic.sv
module tb_tx_logic;
  localparam int W = 8;

  logic PCLK = 1'b0;
  logic CLEAR_B = 1'b0;
  always #5 PCLK = ~PCLK;

  tx_logic_if #(.DATA_WIDTH(W)) bus ();
  tx_logic #(.DATA_WIDTH(W)) dut (.PCLK(PCLK), .CLEAR_B(CLEAR_B), .bus(bus));

  int total = 0;
  int bad = 0;

  logic [W-1:0] fifo[$];
  logic [W-1:0] push_q[$];
  logic [W-1:0] exp_q[$];

  int cyc = 0;
  int rd_cnt = 0;
  int fss_cnt = 0;
  int oe_low_cnt = 0;
  logic rd_prev = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // FIFO model + per-cycle monitor counters, all on negedge PCLK.
  always @(negedge PCLK) begin
    cyc <= cyc + 1;
    if (bus.read_fifo) rd_cnt <= rd_cnt + 1;
    if (bus.SSPFSSOUT) fss_cnt <= fss_cnt + 1;
    if (!bus.SSPOE_B) oe_low_cnt <= oe_low_cnt + 1;
    rd_prev <= bus.read_fifo;
    if (bus.read_fifo && rd_prev) chk("rd_double", 1, 0);
    if (bus.read_fifo) begin
      if (fifo.size() == 0) chk("rd_when_empty", 1, 0);
      else void'(fifo.pop_front());
    end
    while (push_q.size() > 0) fifo.push_back(push_q.pop_front());
    bus.tx_fifo_empty <= (fifo.size() == 0);
    bus.TxData        <= (fifo.size() != 0) ? fifo[0] : '0;
  end

  // Serial receiver / scoreboard monitor: samples on SSPCLKOUT falls.
  logic [W-1:0] rx_sh = '0;
  int           rx_n = 0;
  logic         rx_on = 1'b0;
  always @(negedge bus.SSPCLKOUT or negedge CLEAR_B) begin : rx_blk
    logic [W-1:0] sh;
    int           n;
    logic         on;
    logic [W-1:0] e;
    if (!CLEAR_B) begin
      rx_on <= 1'b0;
      rx_n  <= 0;
    end else begin
      sh = rx_sh; n = rx_n; on = rx_on;
      if (on) begin
        sh = {sh[W-2:0], bus.SSPTXD};
        n++;
        if (n == W) begin
          on = 1'b0;
          n = 0;
          if (exp_q.size() == 0) chk("rx_unexpected", int'(sh), -1);
          else begin
            e = exp_q.pop_front();
            chk("rx_word", int'(sh), int'(e));
          end
        end
      end
      if (bus.SSPFSSOUT) begin
        on = 1'b1;
        n = 0;
      end
      rx_sh <= sh; rx_n <= n; rx_on <= on;
    end
  end

  task automatic negs(input int n);
    repeat (n) @(negedge PCLK);
    #1;
  endtask

  // Word lands in the FIFO at the next negedge.
  task automatic push(input logic [W-1:0] w, input bit expect_rx);
    push_q.push_back(w);
    if (expect_rx) exp_q.push_back(w);
  endtask

  task automatic wait_load(output int at);
    at = -1;
    for (int i = 0; i < 400 && at < 0; i++) begin
      negs(1);
      if (bus.read_fifo) at = cyc;
    end
    if (at < 0) chk("load_timeout", 0, 1);
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      negs(1);
      i++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int s_rd, s_fss, s_oe, t1, t2, t3, tog_err, lvl_err;
    logic prev;

    // Reset values
    #22;
    chk("rst_clk", bus.SSPCLKOUT, 0);
    chk("rst_fss", bus.SSPFSSOUT, 0);
    chk("rst_txd", bus.SSPTXD, 0);
    chk("rst_oe_b", bus.SSPOE_B, 1);
    chk("rst_rd", bus.read_fifo, 0);
    @(negedge PCLK); #1;
    CLEAR_B = 1'b1;

    // Idle with FIFO empty
    s_rd = rd_cnt; tog_err = 0; lvl_err = 0;
    prev = bus.SSPCLKOUT;
    for (int i = 0; i < 20; i++) begin
      negs(1);
      if (bus.SSPCLKOUT === prev) tog_err++;
      prev = bus.SSPCLKOUT;
      if (bus.SSPFSSOUT !== 1'b0 || bus.SSPTXD !== 1'b0 || bus.SSPOE_B !== 1'b1) lvl_err++;
    end
    chk("idle_toggle_err", tog_err, 0);
    chk("idle_level_err", lvl_err, 0);
    chk("idle_rd", rd_cnt - s_rd, 0);

    // Single word 0xA5
    s_rd = rd_cnt; s_fss = fss_cnt; s_oe = oe_low_cnt;
    push(8'hA5, 1);
    wait_load(t1);
    chk("a5_msb_at_load", bus.SSPTXD, 1);
    wait_done(100);
    negs(12);
    chk("a5_fss_len", fss_cnt - s_fss, 2);
    chk("a5_rd_len", rd_cnt - s_rd, 1);
    chk("a5_oe_low_len", oe_low_cnt - s_oe, 18);
    chk("a5_oe_back_high", bus.SSPOE_B, 1);

    // Back-to-back 0x3C, 0xC3
    s_rd = rd_cnt; s_fss = fss_cnt; s_oe = oe_low_cnt;
    push(8'h3C, 1);
    push(8'hC3, 1);
    wait_load(t1);
    negs(14);
    chk("b2b_fss_on_bit0", bus.SSPFSSOUT, 1);
    chk("b2b_bit0_val", bus.SSPTXD, 0);
    wait_load(t2);
    chk("b2b_rd_gap", t2 - t1, 16);
    wait_done(100);
    negs(12);
    chk("b2b_rd_count", rd_cnt - s_rd, 2);
    chk("b2b_fss_len", fss_cnt - s_fss, 4);
    chk("b2b_oe_low_len", oe_low_cnt - s_oe, 34);

    // Late-arrival cases: in time for the last-bit tick vs one tick later
    push(8'h5A, 1);
    wait_load(t1);
    negs(12);
    push(8'h81, 1);
    wait_load(t2);
    chk("cont_rd_gap", t2 - t1, 16);
    negs(14);
    push(8'h7E, 1);
    negs(2);
    chk("late_idle_fss", bus.SSPFSSOUT, 0);
    chk("late_idle_txd", bus.SSPTXD, 0);
    negs(2);
    chk("late_fss_rise", bus.SSPFSSOUT, 1);
    chk("late_fss_txd", bus.SSPTXD, 0);
    wait_load(t3);
    chk("late_rd_gap", t3 - t2, 20);
    wait_done(100);
    negs(4);

    // Abort at bit 4 of 0x96; second copy in the FIFO is sent afterwards
    push(8'h96, 0);
    push(8'h96, 1);
    wait_load(t1);
    negs(8);
    s_rd = rd_cnt;
    CLEAR_B = 1'b0;
    #1;
    chk("abort_clk", bus.SSPCLKOUT, 0);
    chk("abort_fss", bus.SSPFSSOUT, 0);
    chk("abort_txd", bus.SSPTXD, 0);
    chk("abort_oe_b", bus.SSPOE_B, 1);
    chk("abort_rd", bus.read_fifo, 0);
    negs(3);
    chk("abort_rd_cnt", rd_cnt - s_rd, 0);
    chk("abort_fifo_left", fifo.size(), 1);
    CLEAR_B = 1'b1;
    wait_done(100);
    negs(4);

    // Loopback stream
    for (int i = 0; i < 32; i++) push(W'($urandom_range(0, 255)), 1);
    wait_done(2000);
    negs(4);
    chk("stream_fifo_empty", fifo.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
